perf_counter_bank: RTL and testbench

Parametrised bank of event counters that generalises the fixed 8-bit clock/instruction/cache-hit counters exported by the CPU top level. It provides N channels of configurable width, selectable wrap or saturate behaviour, sticky overflow flags, a global run gate, synchronous clear, and an atomic snapshot with registered indexed readout. It sits beside the pipeline top and takes single-cycle event strobes from the core and cache.

---
 rtl/perf_pkg.sv | 17 +
 rtl/perf_counter_ch.sv | 45 ++++
 rtl/perf_counter_bank.sv | 87 ++++++++
 tb/tb_perf_counter_bank.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: constants shared by the performance counter bank and its users.
//   CH_*      : channel index assignments (clock, retired instruction, cache hit)
//   DEF_*     : default bank geometry
//   MODE_*    : values for the SATURATE parameter
package perf_pkg;

  localparam int unsigned CH_CLK  = 0;
  localparam int unsigned CH_INST = 1;
  localparam int unsigned CH_HIT  = 2;

  localparam int unsigned DEF_NUM_CH = 3;
  localparam int unsigned DEF_WIDTH  = 8;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/perf_counter_ch.sv
// perf_counter_ch: one event counter with a sticky overflow flag.
//   clk, rst (async, active-low)
//   en   : global run gate
//   clr  : synchronous clear of cnt and ovf (beats increment)
//   inc  : event strobe, one increment per cycle
//   cnt  : live count
//   ovf  : sticky overflow, set when an increment is attempted at all-ones
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  logic at_max;
  assign at_max = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && inc) begin
      if (at_max) begin
        ovf <= 1'b1;
        if (SATURATE != MODE_SAT) begin
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH independent event counters with atomic snapshot.
//   clk, rst (async, active-low)
//   en         : global run gate
//   clr        : synchronous clear of live counters and overflow flags
//   inc        : per-channel event strobes
//   snap       : copy live counters (pre-edge values) into shadow registers
//   rd_sel     : shadow channel to read
//   rd_data    : registered shadow[rd_sel], 0 when rd_sel is out of range
//   cnt_flat   : live counters, channel i at [i*WIDTH +: WIDTH]
//   ovf        : sticky overflow per channel
//   snap_valid : set by the first snapshot after reset
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       inc,
  input  logic                    snap,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [WIDTH-1:0]        rd_data,
  output logic [NUM_CH*WIDTH-1:0] cnt_flat,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    snap_valid
);

  logic [WIDTH-1:0] live   [NUM_CH];
  logic [WIDTH-1:0] shadow [NUM_CH];
  logic [WIDTH-1:0] rd_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter_ch #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (clr),
      .inc (inc[i]),
      .cnt (live[i]),
      .ovf (ovf[i])
    );
    assign cnt_flat[i*WIDTH +: WIDTH] = live[i];
  end

  // Shadow captures the registered live values, i.e. before this edge's
  // increment or clear, so snap+clr acts as an atomic read-and-reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
      end
      snap_valid <= 1'b0;
    end else if (snap) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= live[i];
      end
      snap_valid <= 1'b1;
    end
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_next = shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: three bank configurations (8-bit wrap, 4-bit wrap,
// 4-bit saturate) share one stimulus stream and are compared against an
// integer reference model every cycle.
module tb_perf_counter_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [2:0]  inc;
  logic        snap;
  logic [1:0]  rd_sel;

  logic [7:0]  rd8;
  logic [3:0]  rd4w, rd4s;
  logic [23:0] cnt8;
  logic [11:0] cnt4w, cnt4s;
  logic [2:0]  ovf8, ovf4w, ovf4s;
  logic        sv8, sv4w, sv4s;

  int errors = 0;
  int checks = 0;

  // Reference model state, indexed [instance][channel]
  int unsigned mx [3] = '{255, 15, 15};
  bit          sat[3] = '{1'b0, 1'b0, 1'b1};
  int unsigned m_cnt[3][3];
  bit          m_ovf[3][3];
  int unsigned m_sh [3][3];
  int unsigned m_rd [3];
  bit          m_sv;

  perf_counter_bank #(.NUM_CH(3), .WIDTH(8), .SATURATE(perf_pkg::MODE_WRAP)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .inc(inc), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd8), .cnt_flat(cnt8), .ovf(ovf8), .snap_valid(sv8));

  perf_counter_bank #(.NUM_CH(3), .WIDTH(4), .SATURATE(perf_pkg::MODE_WRAP)) u_w4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .inc(inc), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd4w), .cnt_flat(cnt4w), .ovf(ovf4w), .snap_valid(sv4w));

  perf_counter_bank #(.NUM_CH(3), .WIDTH(4), .SATURATE(perf_pkg::MODE_SAT)) u_s4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .inc(inc), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd4s), .cnt_flat(cnt4s), .ovf(ovf4s), .snap_valid(sv4s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] get_cnt(int k, int ch);
    case (k)
      0:       return 32'(cnt8[ch*8 +: 8]);
      1:       return 32'(cnt4w[ch*4 +: 4]);
      default: return 32'(cnt4s[ch*4 +: 4]);
    endcase
  endfunction

  function automatic logic get_ovf(int k, int ch);
    case (k)
      0:       return ovf8[ch];
      1:       return ovf4w[ch];
      default: return ovf4s[ch];
    endcase
  endfunction

  function automatic logic [31:0] get_rd(int k);
    case (k)
      0:       return 32'(rd8);
      1:       return 32'(rd4w);
      default: return 32'(rd4s);
    endcase
  endfunction

  function automatic logic get_sv(int k);
    case (k)
      0:       return sv8;
      1:       return sv4w;
      default: return sv4s;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rd[k] = 0;
      for (int ch = 0; ch < 3; ch++) begin
        m_cnt[k][ch] = 0;
        m_ovf[k][ch] = 1'b0;
        m_sh[k][ch]  = 0;
      end
    end
    m_sv = 1'b0;
  endtask

  // Drive one cycle of stimulus (called at negedge), advance the model at the
  // posedge, and return at the following negedge ready for sampling.
  task automatic cycle(input bit e, input bit c, input bit s,
                       input logic [2:0] in, input logic [1:0] sel);
    en = e; clr = c; snap = s; inc = in; rd_sel = sel;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_rd[k] = (sel < 3) ? m_sh[k][sel] : 0;
      if (s) for (int ch = 0; ch < 3; ch++) m_sh[k][ch] = m_cnt[k][ch];
      for (int ch = 0; ch < 3; ch++) begin
        if (c) begin
          m_cnt[k][ch] = 0;
          m_ovf[k][ch] = 1'b0;
        end else if (e && in[ch]) begin
          if (m_cnt[k][ch] + 1 > mx[k]) begin
            m_ovf[k][ch] = 1'b1;
            m_cnt[k][ch] = sat[k] ? mx[k] : 0;
          end else begin
            m_cnt[k][ch] = m_cnt[k][ch] + 1;
          end
        end
      end
    end
    if (s) m_sv = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; inc = '0; snap = 1'b0; rd_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_cnt(k, 0) !== 0 || get_rd(k) !== 0 || get_sv(k) !== 1'b0 || get_ovf(k, 0) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst=%0d cnt0=%0d rd=%0d sv=%b ovf0=%b required all 0",
                 k, get_cnt(k, 0), get_rd(k), get_sv(k), get_ovf(k, 0));
      end
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, (i == 2), 3'b111, 2'd0);
    // Mid-cycle async assertion: outputs must drop before the next edge
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (get_cnt(k, ch) !== 0 || get_ovf(k, ch) !== 1'b0) begin
          errors++;
          $display("FAIL async_reset_cnt inst=%0d ch=%0d got cnt=%0d ovf=%b required 0/0",
                   k, ch, get_cnt(k, ch), get_ovf(k, ch));
        end
      end
      checks++;
      if (get_rd(k) !== 0 || get_sv(k) !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_rd inst=%0d got rd=%0d sv=%b required 0/0", k, get_rd(k), get_sv(k));
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 1'b0, 3'b000, 2'd0);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'b010, 2'd0);
      for (int k = 0; k < 3; k++) for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (get_cnt(k, ch) !== m_cnt[k][ch] || get_ovf(k, ch) !== m_ovf[k][ch]) begin
          errors++;
          $display("FAIL wrap step=%0d inst=%0d ch=%0d got cnt=%0d ovf=%b required cnt=%0d ovf=%b",
                   i, k, ch, get_cnt(k, ch), get_ovf(k, ch), m_cnt[k][ch], m_ovf[k][ch]);
        end
      end
    end
    // Independent anchor: 4-bit wrap ch1 after 17 increments is 1 with ovf set
    checks++;
    if (get_cnt(1, 1) !== 1 || get_ovf(1, 1) !== 1'b1 || get_ovf(1, 0) !== 1'b0 || get_ovf(1, 2) !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final got cnt1=%0d ovf=%b%b%b required cnt1=1 ovf=010",
               get_cnt(1, 1), get_ovf(1, 2), get_ovf(1, 1), get_ovf(1, 0));
    end
  endtask

  task automatic test_saturate();
    cycle(1'b1, 1'b1, 1'b0, 3'b000, 2'd0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'b100, 2'd0);
      for (int k = 0; k < 3; k++) for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (get_cnt(k, ch) !== m_cnt[k][ch] || get_ovf(k, ch) !== m_ovf[k][ch]) begin
          errors++;
          $display("FAIL saturate attempt=%0d inst=%0d ch=%0d got cnt=%0d ovf=%b required cnt=%0d ovf=%b",
                   i, k, ch, get_cnt(k, ch), get_ovf(k, ch), m_cnt[k][ch], m_ovf[k][ch]);
        end
      end
      checks++;
      if (get_ovf(2, 2) !== (i >= 16) || get_cnt(2, 2) !== ((i < 15) ? i : 15)) begin
        errors++;
        $display("FAIL saturate_anchor attempt=%0d got cnt=%0d ovf=%b required cnt=%0d ovf=%b",
                 i, get_cnt(2, 2), get_ovf(2, 2), (i < 15) ? i : 15, (i >= 16));
      end
    end
  endtask

  task automatic test_snap_clr();
    logic [31:0] want8 [3] = '{40, 12, 7};
    cycle(1'b1, 1'b1, 1'b0, 3'b000, 2'd0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, {i < 7, i < 12, 1'b1}, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 3'b111, 2'd0);
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (get_cnt(k, ch) !== 0) begin
          errors++;
          $display("FAIL snapclr_live inst=%0d ch=%0d got %0d required 0", k, ch, get_cnt(k, ch));
        end
      end
      checks++;
      if (get_sv(k) !== 1'b1) begin
        errors++;
        $display("FAIL snapclr_valid inst=%0d got %b required 1", k, get_sv(k));
      end
    end
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'b000, 2'(s));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (get_rd(k) !== m_rd[k]) begin
          errors++;
          $display("FAIL snapclr_read inst=%0d sel=%0d got %0d required %0d", k, s, get_rd(k), m_rd[k]);
        end
      end
      checks++;
      if (get_rd(0) !== want8[s]) begin
        errors++;
        $display("FAIL snapclr_read8 sel=%0d got %0d required %0d", s, get_rd(0), want8[s]);
      end
    end
  endtask

  task automatic test_gating();
    logic [31:0] held [3][3];
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 1'b0, 3'b111, 2'd0);
    for (int k = 0; k < 3; k++) for (int ch = 0; ch < 3; ch++) held[k][ch] = get_cnt(k, ch);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'b111, 2'd0);
      for (int k = 0; k < 3; k++) for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (get_cnt(k, ch) !== m_cnt[k][ch] || get_cnt(k, ch) !== held[k][ch] ||
            get_ovf(k, ch) !== m_ovf[k][ch]) begin
          errors++;
          $display("FAIL gating inst=%0d ch=%0d got cnt=%0d ovf=%b required cnt=%0d ovf=%b",
                   k, ch, get_cnt(k, ch), get_ovf(k, ch), m_cnt[k][ch], m_ovf[k][ch]);
        end
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 3'b111, 2'd0);
    for (int k = 0; k < 3; k++) for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (get_cnt(k, ch) !== 0 || get_ovf(k, ch) !== 1'b0) begin
        errors++;
        $display("FAIL gating_clr inst=%0d ch=%0d got cnt=%0d ovf=%b required 0/0",
                 k, ch, get_cnt(k, ch), get_ovf(k, ch));
      end
    end
  endtask

  task automatic test_oob_select();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, (i == 4), 3'b111, 2'd2);
    cycle(1'b1, 1'b0, 1'b0, 3'b000, 2'd2);
    cycle(1'b1, 1'b0, 1'b0, 3'b000, 2'd3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_rd(k) !== 0 || m_rd[k] != 0) begin
        errors++;
        $display("FAIL oob_select inst=%0d got %0d required 0", k, get_rd(k));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
            3'($urandom), 2'($urandom));
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (get_cnt(k, ch) !== m_cnt[k][ch] || get_ovf(k, ch) !== m_ovf[k][ch]) begin
            errors++;
            $display("FAIL random_live cyc=%0d inst=%0d ch=%0d got cnt=%0d ovf=%b required cnt=%0d ovf=%b",
                     i, k, ch, get_cnt(k, ch), get_ovf(k, ch), m_cnt[k][ch], m_ovf[k][ch]);
          end
        end
        checks++;
        if (get_rd(k) !== m_rd[k] || get_sv(k) !== m_sv) begin
          errors++;
          $display("FAIL random_read cyc=%0d inst=%0d got rd=%0d sv=%b required rd=%0d sv=%b",
                   i, k, get_rd(k), get_sv(k), m_rd[k], m_sv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_snap_clr();
    test_gating();
    test_oob_select();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
